sprite_blitter: RTL

Sprite blit engine: on a start pulse, reads a rectangular sprite out of a synchronous-read sprite ROM (12-bit RGB, one pixel per address, row-major, 1-cycle read latency) and writes it into the framebuffer write port at a given screen position. It sits between the game-logic FSM, which issues draw commands, and the framebuffer RAM. It is the initiator side of the ROM read interface, and the writer side of the framebuffer port.

---
 rtl/sprite_blitter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// Sprite blit engine: streams a rectangular sprite from a sync-read ROM into the framebuffer write port.
// Optional colour-key transparency is enabled by defining SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
    parameter int DATA_WIDTH    = 12,
    parameter int ADDR_WIDTH    = 14,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int FB_WIDTH      = 320,
    parameter int FB_HEIGHT     = 240,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'h0F0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    src_base,
    input  logic [7:0]               spr_w,
    input  logic [7:0]               spr_h,
    input  logic [8:0]               dst_x,
    input  logic [7:0]               dst_y,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0]    fb_data,
    output logic                     fb_we
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [7:0] w_q, h_q, col, row, p_col, p_row;
    logic [8:0] x_q;
    logic [7:0] y_q;
    logic       p_vld;
    logic       drain_cnt;
    logic       zero_pend;
    logic       last, zero_cmd, skip, in_bounds;
    logic [9:0] xs;
    logic [8:0] ys;
    logic [17:0] lin;

    assign zero_cmd = (spr_w == 8'd0) || (spr_h == 8'd0);
    assign last     = (col == w_q - 8'd1) && (row == h_q - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A zero-size command spends one silent cycle in DONE (zero_pend) before pulsing done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = zero_cmd ? DONE : RUN;
            RUN:   if (last) state_next = DRAIN;
            DRAIN: if (drain_cnt) state_next = DONE;
            DONE:  if (!zero_pend) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE) && !zero_pend;

    // Addresses are row-major and contiguous, so the ROM address simply increments.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col       <= '0;
            row       <= '0;
            rom_addr  <= '0;
            drain_cnt <= 1'b0;
            zero_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    w_q       <= spr_w;
                    h_q       <= spr_h;
                    x_q       <= dst_x;
                    y_q       <= dst_y;
                    col       <= '0;
                    row       <= '0;
                    drain_cnt <= 1'b0;
                    zero_pend <= zero_cmd;
                    if (!zero_cmd) rom_addr <= src_base;
                end
                RUN: if (!last) begin
                    rom_addr <= rom_addr + 1'b1;
                    if (col == w_q - 8'd1) begin
                        col <= '0;
                        row <= row + 8'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                DONE:  zero_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    assign xs  = {1'b0, x_q} + {2'b00, p_col};
    assign ys  = {1'b0, y_q} + {1'b0, p_row};
    assign lin = 18'(ys) * 18'(FB_WIDTH) + 18'(xs);
    assign in_bounds = (xs < 10'(FB_WIDTH)) && (ys < 9'(FB_HEIGHT));

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    assign skip = (rom_data == KEY_COLOR);
`else
    assign skip = 1'b0;
`endif

    // p_* lines up a pixel's coordinates with the cycle its rom_data is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_vld   <= 1'b0;
            p_col   <= '0;
            p_row   <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            p_vld <= (state == RUN);
            p_col <= col;
            p_row <= row;
            fb_we <= p_vld && in_bounds && !skip;
            if (p_vld) begin
                fb_addr <= FB_ADDR_WIDTH'(lin);
                fb_data <= rom_data;
            end
        end
    end

endmodule
